r_separator: RTL and testbench

- Receive-side counterpart of the transmit byte multiplexer.
- Takes the received byte stream (one byte per strobe) and delineates frames laid out as LEN, LEN SDP payload bytes, CRC.
- Steers payload bytes and the CRC byte onto separate strobed lanes, recomputes CRC-8, and flags frame OK/error.
- Sits between the byte receiver and the SDP consumer / CRC checker logic.

---
 rtl/r_separator.sv | 217 +++++++++++++++++++++
 tb/tb_r_separator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_separator.sv
// ---------------------------------------------------------------------------
// r_separator
//   Receive-side frame separator. Delineates a received byte stream into
//   frames of the form LEN, LEN payload bytes, CRC; steers payload bytes and
//   the CRC byte onto separate strobed lanes, recomputes CRC-8 over LEN and
//   payload, and flags each frame as OK or errored.
//
// Ports
//   clk        in   1  system clock, rising edge
//   n_rst      in   1  asynchronous active-low reset
//   d_src      in   8  received byte
//   d_rdy_src  in   1  one-cycle strobe: d_src valid
//   rx_state   out  2  [0] receiving payload, [1] awaiting/receiving CRC byte
//   d_rdy_dst  out  2  [0] payload byte strobe, [1] CRC byte strobe
//   d_dst      out 16  [7:0] last payload byte, [15:8] last received CRC byte
//   frame_ok   out  1  one-cycle pulse: CRC matched
//   frame_err  out  1  one-cycle pulse: frame aborted
//   err_code   out  2  valid with frame_err: 1 CRC, 2 length, 3 timeout
// ---------------------------------------------------------------------------
module r_separator #(
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] CRC_POLY       = 8'h07,
  parameter logic [7:0] CRC_INIT       = 8'h00
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  d_src,
  input  logic        d_rdy_src,
  output logic [1:0]  rx_state,
  output logic [1:0]  d_rdy_dst,
  output logic [15:0] d_dst,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int         GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SDP     = 2'd1,
    ST_CRC     = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  state_e           state_q;
  logic [7:0]       crc_q;
  logic [7:0]       remaining_q;
  logic [GAP_W-1:0] gap_q;
  logic [1:0]       rx_state_q;
  logic [1:0]       d_rdy_dst_q;
  logic [7:0]       sdp_byte_q;
  logic [7:0]       crc_byte_q;
  logic             frame_ok_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;

  // Fold one byte into a CRC-8 register: MSB first, all eight steps in one clock.
  function automatic logic [7:0] crc_fold(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [1:0] rx_decode(input state_e s);
    case (s)
      ST_SDP:  return 2'b01;
      ST_CRC:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  logic [7:0] crc_len_d;   // CRC after the LEN byte, seeded fresh
  logic [7:0] crc_upd_d;   // CRC after folding the current payload byte
  logic       gap_hit;     // this idle clock is the one that exhausts the gap budget

  assign crc_len_d = crc_fold(CRC_INIT, d_src);
  assign crc_upd_d = crc_fold(crc_q, d_src);
  // A strobe in the expiring cycle wins, hence the !d_rdy_src term.
  assign gap_hit   = !d_rdy_src && (gap_q == GAP_LAST);

  // NOTE: every register here, including the output registers, gets a
  // reset value, and all updates use non-blocking assignment so that every
  // branch reads the pre-edge value of the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      remaining_q <= '0;
      gap_q       <= '0;
      rx_state_q  <= 2'b00;
      d_rdy_dst_q <= 2'b00;
      sdp_byte_q  <= '0;
      crc_byte_q  <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      d_rdy_dst_q <= 2'b00;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          gap_q <= '0;
          if (d_rdy_src) begin
            crc_q <= crc_len_d;
            if (d_src == 8'd0) begin
              state_q    <= ST_CRC;
              rx_state_q <= rx_decode(ST_CRC);
            end else if (d_src <= MAX_LEN_B) begin
              remaining_q <= d_src;
              state_q     <= ST_SDP;
              rx_state_q  <= rx_decode(ST_SDP);
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
              state_q     <= ST_DISCARD;
              rx_state_q  <= rx_decode(ST_DISCARD);
            end
          end
        end

        ST_SDP: begin
          if (d_rdy_src) begin
            gap_q          <= '0;
            sdp_byte_q     <= d_src;
            d_rdy_dst_q[0] <= 1'b1;
            crc_q          <= crc_upd_d;
            remaining_q    <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_q    <= ST_CRC;
              rx_state_q <= rx_decode(ST_CRC);
            end
          end else if (gap_hit) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            crc_q       <= CRC_INIT;
            remaining_q <= '0;
            gap_q       <= '0;
            state_q     <= ST_IDLE;
            rx_state_q  <= rx_decode(ST_IDLE);
          end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + 1'b1;
          end
        end

        ST_CRC: begin
          if (d_rdy_src) begin
            crc_byte_q     <= d_src;
            d_rdy_dst_q[1] <= 1'b1;
            if (d_src == crc_q) begin
              frame_ok_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CRC;
            end
            crc_q       <= CRC_INIT;
            remaining_q <= '0;
            gap_q       <= '0;
            state_q     <= ST_IDLE;
            rx_state_q  <= rx_decode(ST_IDLE);
          end else if (gap_hit) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            crc_q       <= CRC_INIT;
            remaining_q <= '0;
            gap_q       <= '0;
            state_q     <= ST_IDLE;
            rx_state_q  <= rx_decode(ST_IDLE);
          end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + 1'b1;
          end
        end

        ST_DISCARD: begin
          // Bytes are dropped; only a full quiet gap resynchronises.
          if (d_rdy_src) begin
            gap_q <= '0;
          end else if (gap_hit) begin
            crc_q      <= CRC_INIT;
            gap_q      <= '0;
            state_q    <= ST_IDLE;
            rx_state_q <= rx_decode(ST_IDLE);
          end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          rx_state_q <= rx_decode(ST_IDLE);
        end
      endcase
    end
  end

  assign rx_state  = rx_state_q;
  assign d_rdy_dst = d_rdy_dst_q;
  assign d_dst     = {crc_byte_q, sdp_byte_q};
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_r_separator.sv
// ---------------------------------------------------------------------------
// tb_r_separator
//   Self-checking bench for r_separator. A driver issues bytes one clock at a
//   time and feeds a frame-level reference model, which pushes the expected
//   output events (with the cycle they must appear in) into a scoreboard
//   queue. An independent monitor compares DUT outputs against that queue.
// ---------------------------------------------------------------------------
module tb_r_separator;

  localparam int MAX_LEN = 64;
  localparam int TMO     = 1024;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  d_src = 8'h00;
  logic        d_rdy_src = 1'b0;
  logic [1:0]  rx_state;
  logic [1:0]  d_rdy_dst;
  logic [15:0] d_dst;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;

  r_separator #(
    .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .CRC_POLY(8'h07), .CRC_INIT(8'h00)
  ) dut (
    .clk(clk), .n_rst(n_rst), .d_src(d_src), .d_rdy_src(d_rdy_src),
    .rx_state(rx_state), .d_rdy_dst(d_rdy_dst), .d_dst(d_dst),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef enum int {EV_SDP = 0, EV_CRC = 1, EV_OK = 2, EV_ERR = 3} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    logic [1:0] code;
    int         at;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] exp_rx[int];

  function automatic void push_ev(input ev_kind_e k, input logic [7:0] d,
                                  input logic [1:0] c, input int t);
    ev_t e;
    e.kind = k; e.data = d; e.code = c; e.at = t;
    exp_q.push_back(e);
  endfunction

  // ---------------- reference model ----------------
  // Frame-level view: collect the frame bytes, and on the CRC byte compute
  // the CRC-8 of everything collected as one long-division over the bit string.
  typedef enum int {M_IDLE, M_PAYLOAD, M_CRCB, M_DROP} mode_e;
  mode_e      mode = M_IDLE;
  logic [7:0] frame[$];
  int         want_len = 0;
  int         quiet = 0;

  function automatic logic [7:0] crc8_of(input logic [7:0] q[$]);
    logic [7:0] r;
    r = 8'h00;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        logic top;
        top = r[7] ^ q[i][b];
        r = {r[6:0], 1'b0};
        if (top) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  task automatic model_step(input bit s, input logic [7:0] b);
    int t;
    t = cyc + 1;
    if (s) begin
      quiet = 0;
      case (mode)
        M_IDLE: begin
          frame = {b};
          if (b == 8'd0) mode = M_CRCB;
          else if (int'(b) <= MAX_LEN) begin mode = M_PAYLOAD; want_len = int'(b); end
          else begin push_ev(EV_ERR, 8'h00, 2'd2, t); mode = M_DROP; end
        end
        M_PAYLOAD: begin
          frame.push_back(b);
          push_ev(EV_SDP, b, 2'd0, t);
          if (frame.size() == want_len + 1) mode = M_CRCB;
        end
        M_CRCB: begin
          push_ev(EV_CRC, b, 2'd0, t);
          if (b == crc8_of(frame)) push_ev(EV_OK, 8'h00, 2'd0, t);
          else push_ev(EV_ERR, 8'h00, 2'd1, t);
          mode = M_IDLE;
        end
        default: ;
      endcase
    end else if (mode != M_IDLE) begin
      quiet++;
      if (quiet == TMO) begin
        if (mode != M_DROP) push_ev(EV_ERR, 8'h00, 2'd3, t);
        mode  = M_IDLE;
        quiet = 0;
      end
    end
    exp_rx[t] = (mode == M_PAYLOAD) ? 2'b01 : (mode == M_CRCB) ? 2'b10 : 2'b00;
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input bit s, input logic [7:0] b);
    @(negedge clk);
    d_rdy_src = s;
    d_src     = b;
    model_step(s, b);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask

  // ---------------- monitor ----------------
  task automatic expect_ev(input ev_kind_e k, input logic [7:0] d, input logic [1:0] c);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d with nothing expected (cycle %0d)", k, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.at);
      if (k == EV_SDP || k == EV_CRC) check("event_data", d, e.data);
      if (k == EV_ERR) check("err_code", c, e.code);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        checks++; errors++;
        $display("FAIL missing_event: got none expected kind %0d at cycle %0d", exp_q[0].kind, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (exp_rx.exists(cyc)) begin
        check("rx_state", rx_state, exp_rx[cyc]);
        exp_rx.delete(cyc);
      end
      check("ok_err_exclusive", frame_ok & frame_err, 1'b0);
      if (d_rdy_dst[0]) expect_ev(EV_SDP, d_dst[7:0], 2'd0);
      if (d_rdy_dst[1]) expect_ev(EV_CRC, d_dst[15:8], 2'd0);
      if (frame_ok)     expect_ev(EV_OK, 8'h00, 2'd0);
      if (frame_err)    expect_ev(EV_ERR, 8'h00, err_code);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_state"}, rx_state, 2'b00);
    check({tag, "_d_rdy_dst"}, d_rdy_dst, 2'b00);
    check({tag, "_d_dst"}, d_dst, 16'h0000);
    check({tag, "_frame_ok"}, frame_ok, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_err_code"}, err_code, 2'b00);
  endtask

  task automatic send_random_frame();
    int         len;
    int         r;
    logic [7:0] body[$];
    r = $urandom_range(0, 99);
    if (r < 4) begin
      // Oversize LEN, a few trailing bytes, then a full resync gap.
      send(8'($urandom_range(MAX_LEN + 1, 255)));
      repeat ($urandom_range(0, 3)) send(8'($urandom));
      idle(TMO + $urandom_range(0, 3));
      return;
    end
    len  = (r < 30) ? $urandom_range(0, 3) : $urandom_range(0, MAX_LEN);
    body = {8'(len)};
    for (int i = 0; i < len; i++) body.push_back(8'($urandom));
    if (r < 8) begin
      // Truncated frame: stop partway and let the gap timer abort it.
      for (int i = 0; i < $urandom_range(1, len + 1); i++) send(body[i]);
      idle(TMO + $urandom_range(0, 3));
      return;
    end
    foreach (body[i]) begin
      send(body[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    if ($urandom_range(0, 4) == 0) send(crc8_of(body) ^ 8'($urandom_range(1, 255)));
    else send(crc8_of(body));
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle(2);

    // Single-byte payload, back to back, good CRC.
    send(8'h01); send(8'h00); send(8'h15);
    idle(3);
    // Empty payload.
    send(8'h00); send(8'h00);
    idle(3);
    // Bad CRC followed immediately by a good frame.
    send(8'h01); send(8'h00); send(8'h16);
    send(8'h01); send(8'h00); send(8'h15);
    idle(3);
    // Oversize LEN, trailing bytes dropped, resync after a full gap.
    send(8'd65); send(8'h11); send(8'h22); send(8'h33);
    idle(TMO + 2);
    send(8'h01); send(8'h00); send(8'h15);
    idle(3);
    // A byte at gap count TMO-1 is accepted, then a full stall times out.
    send(8'h03); send(8'hAA);
    idle(TMO - 1);
    send(8'h55);
    idle(TMO + 2);
    // Timeout while waiting for the CRC byte.
    send(8'h01); send(8'h42);
    idle(TMO + 2);
    // Good frame right after a timeout.
    send(8'h02); send(8'hDE); send(8'hAD); send(crc8_of('{8'h02, 8'hDE, 8'hAD}));
    idle(3);

    // Reset in the middle of a payload.
    send(8'h05); send(8'hAA); send(8'hBB);
    @(posedge clk);
    #2;
    n_rst     = 1'b0;
    d_rdy_src = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    exp_rx.delete();
    mode  = M_IDLE;
    quiet = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle(1);
    send(8'h00); send(8'h00);
    idle(3);

    // Randomised frames.
    for (int n = 0; n < 150; n++) send_random_frame();

    idle(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
